fsbm_search_ctrl: RTL and testbench
===================================

FSBM_SEARCH_CTRL -- requirements
Module: fsbm_search_ctrl

Interface
REQ-001 Parameter SR, default 8, search range; candidate displacements are -SR..SR-1 on each axis, giving (2*SR)^2 candidates.
REQ-002 Parameter SAD_W, default 12, width of the SAD value returned by the PE.
REQ-003 Parameter MV_W, default 5, signed width of each displacement component; MV_W SHALL hold -SR..SR-1.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a full search; sampled only in IDLE.
REQ-007 fetch_ready  in  1  the window fetch can supply operands for the current candidate this cycle.
REQ-008 pe_sum  in  SAD_W  registered SAD from the PE; valid the cycle after pe_enable.
REQ-009 pe_enable  out  1  drives the PE enable; high means the current candidate is issued this cycle.
REQ-010 cand_dx, cand_dy  out  MV_W signed  displacement of the candidate being issued.
REQ-011 busy  out  1  high from start acceptance until done.
REQ-012 done  out  1  one-cycle pulse when the result is final.
REQ-013 best_sad  out  SAD_W  minimum SAD found.
REQ-014 best_dx, best_dy  out  MV_W signed  displacement of the minimum SAD.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-016 State transitions SHALL be: IDLE->RUN on start; RUN->DRAIN on issue of the last candidate; DRAIN->DONE after one cycle; DONE->IDLE after one cycle.
REQ-017 On start acceptance, cand_dx and cand_dy SHALL load -SR and best_sad SHALL load all-ones.
REQ-018 pe_enable SHALL equal (state==RUN && fetch_ready) and SHALL be combinational.
REQ-019 Candidates SHALL advance only when pe_enable is high.
REQ-020 Scan order SHALL be raster: cand_dx increments; after SR-1, cand_dx wraps to -SR and cand_dy increments.
REQ-021 The last candidate SHALL be (SR-1, SR-1); its issue SHALL move the FSM to DRAIN.
REQ-022 When fetch_ready is low in RUN, cand_dx and cand_dy SHALL hold and no candidate SHALL be issued.
REQ-023 A one-stage tag pipeline SHALL register pe_enable, cand_dx and cand_dy; when the registered enable is high, pe_sum SHALL be compared against best_sad that cycle.
REQ-024 Comparison SHALL be unsigned strict less-than; on true, best_sad, best_dx and best_dy SHALL update from pe_sum and the tagged displacement.
REQ-025 Ties SHALL keep the earlier candidate in raster order.
REQ-026 The first candidate SHALL always win, because the maximum SAD (16*255=4080) is below 4095.
REQ-027 DRAIN SHALL absorb the compare of the final candidate.
REQ-028 done SHALL be high only in DONE.
REQ-029 busy SHALL be high in RUN and DRAIN and low in IDLE and DONE.
REQ-030 With fetch_ready held high, done SHALL assert exactly (2*SR)^2+2 cycles after the start-accepting edge (258 for SR=8).
REQ-031 start in any state other than IDLE SHALL be ignored.
REQ-032 start in DONE SHALL NOT be queued.
REQ-033 best_sad, best_dx and best_dy SHALL hold after done until the next start acceptance.

Reset
REQ-034 When rst_n is low at a rising edge, the FSM SHALL enter IDLE, and cand_dx, cand_dy, best_sad, best_dx, best_dy and the tag pipeline SHALL clear to 0.
REQ-035 When rst_n is low at a rising edge, busy and done SHALL clear to 0.
REQ-036 Reset mid-search SHALL abort the search with no done pulse; pe_enable SHALL be 0 from the following cycle.

Structure
REQ-037 Package fsbm_pkg SHALL hold SR, SAD_W, MV_W defaults and the state enum (IDLE, RUN, DRAIN, DONE).
REQ-038 The raster counter SHALL be sub-module fsbm_scan_cnt, with inputs clk, rst_n, load, advance and outputs dx, dy, last.
REQ-039 The comparator and tag pipeline SHALL stay in the top module.

Verification
REQ-040 Scenario: SR=8, fetch_ready=1, PE model returns |dx-3|+|dy+2|+10 -> done at cycle 258, best_sad=10, best_dx=3, best_dy=-2.
REQ-041 Scenario: all candidates return SAD 50 -> best=(-8,-8), best_sad=50 (tie rule).
REQ-042 Scenario: fetch_ready toggled pseudo-randomly -> same result as REQ-040, exactly 256 pe_enable pulses, no candidate repeated or skipped.
REQ-043 Scenario: minimum placed only at (7,7) -> DRAIN compare captures it; best=(7,7).
REQ-044 Scenario: start asserted in RUN and in DONE -> ignored; one done pulse only.
REQ-045 Scenario: rst_n low at candidate 100 -> IDLE next cycle, all outputs 0, no done; a new start then completes normally.

Source files
------------

// File: rtl/fsbm_pkg.sv
// Shared defaults and state encoding for the full-search block-matching controller.
package fsbm_pkg;

    localparam int SR_DEF    = 8;
    localparam int SAD_W_DEF = 12;
    localparam int MV_W_DEF  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fsbm_scan_cnt.sv
// Raster-order displacement counter: dx sweeps -SR..SR-1, then dy steps.
module fsbm_scan_cnt
    import fsbm_pkg::*;
#(
    parameter int SR   = SR_DEF,
    parameter int MV_W = MV_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   advance,
    output logic signed [MV_W-1:0] dx,
    output logic signed [MV_W-1:0] dy,
    output logic                   last
);

    localparam logic signed [MV_W-1:0] MIN_V = MV_W'(-SR);
    localparam logic signed [MV_W-1:0] MAX_V = MV_W'(SR - 1);
    localparam logic signed [MV_W-1:0] ONE_V = MV_W'(1);

    logic signed [MV_W-1:0] dx_q, dx_d;
    logic signed [MV_W-1:0] dy_q, dy_d;

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (load) begin
            dx_d = MIN_V;
            dy_d = MIN_V;
        end else if (advance) begin
            if (dx_q == MAX_V) begin
                dx_d = MIN_V;
                dy_d = dy_q + ONE_V;
            end else begin
                dx_d = dx_q + ONE_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx   = dx_q;
    assign dy   = dy_q;
    assign last = (dx_q == MAX_V) && (dy_q == MAX_V);

endmodule

// File: rtl/fsbm_search_ctrl.sv
// Full-search motion estimation controller: issues every candidate to the PE
// and keeps the earliest minimum-SAD displacement.
module fsbm_search_ctrl
    import fsbm_pkg::*;
#(
    parameter int SR    = SR_DEF,
    parameter int SAD_W = SAD_W_DEF,
    parameter int MV_W  = MV_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   fetch_ready,
    input  logic [SAD_W-1:0]       pe_sum,
    output logic                   pe_enable,
    output logic signed [MV_W-1:0] cand_dx,
    output logic signed [MV_W-1:0] cand_dy,
    output logic                   busy,
    output logic                   done,
    output logic [SAD_W-1:0]       best_sad,
    output logic signed [MV_W-1:0] best_dx,
    output logic signed [MV_W-1:0] best_dy
);

    state_e state_q, state_d;
    logic   start_acc;
    logic   last_cand;

    logic                   tag_v_q;
    logic signed [MV_W-1:0] tag_dx_q, tag_dy_q;

    logic [SAD_W-1:0]       best_sad_q, best_sad_d;
    logic signed [MV_W-1:0] best_dx_q, best_dx_d;
    logic signed [MV_W-1:0] best_dy_q, best_dy_d;

    assign start_acc = (state_q == IDLE) && start;
    assign pe_enable = (state_q == RUN) && fetch_ready;

    fsbm_scan_cnt #(
        .SR   (SR),
        .MV_W (MV_W)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start_acc),
        .advance (pe_enable),
        .dx      (cand_dx),
        .dy      (cand_dy),
        .last    (last_cand)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (pe_enable && last_cand) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strict less-than keeps the earlier raster candidate on ties.
    always_comb begin
        best_sad_d = best_sad_q;
        best_dx_d  = best_dx_q;
        best_dy_d  = best_dy_q;
        if (start_acc) begin
            best_sad_d = '1;
        end else if (tag_v_q && (pe_sum < best_sad_q)) begin
            best_sad_d = pe_sum;
            best_dx_d  = tag_dx_q;
            best_dy_d  = tag_dy_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tag_v_q    <= 1'b0;
            tag_dx_q   <= '0;
            tag_dy_q   <= '0;
            best_sad_q <= '0;
            best_dx_q  <= '0;
            best_dy_q  <= '0;
        end else begin
            state_q    <= state_d;
            tag_v_q    <= pe_enable;
            tag_dx_q   <= cand_dx;
            tag_dy_q   <= cand_dy;
            best_sad_q <= best_sad_d;
            best_dx_q  <= best_dx_d;
            best_dy_q  <= best_dy_d;
        end
    end

    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign best_sad = best_sad_q;
    assign best_dx  = best_dx_q;
    assign best_dy  = best_dy_q;

endmodule

// File: tb/tb_fsbm_search_ctrl.sv
// Directed bench for fsbm_search_ctrl with a behavioural one-cycle PE model.
module tb_fsbm_search_ctrl;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              fetch_ready = 1'b0;
    logic [11:0]       pe_sum = '0;
    logic              pe_enable;
    logic signed [4:0] cand_dx, cand_dy;
    logic              busy, done;
    logic [11:0]       best_sad;
    logic signed [4:0] best_dx, best_dy;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor / PE model state (written only by the always block below).
    int mode = 0;
    logic mon_clr = 1'b0;
    int pulses = 0;
    int order_err = 0;
    int exp_dx = -8;
    int exp_dy = -8;

    fsbm_search_ctrl #(.SR(8), .SAD_W(12), .MV_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .fetch_ready (fetch_ready),
        .pe_sum      (pe_sum),
        .pe_enable   (pe_enable),
        .cand_dx     (cand_dx),
        .cand_dy     (cand_dy),
        .busy        (busy),
        .done        (done),
        .best_sad    (best_sad),
        .best_dx     (best_dx),
        .best_dy     (best_dy)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [11:0] sad_f(input int m, input int dx, input int dy);
        case (m)
            0:       return 12'(iabs(dx - 3) + iabs(dy + 2) + 10);
            1:       return 12'd50;
            default: return (dx == 7 && dy == 7) ? 12'd5 : 12'd100;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mon_clr) begin
            pulses    = 0;
            order_err = 0;
            exp_dx    = -8;
            exp_dy    = -8;
        end else if (pe_enable) begin
            pe_sum <= sad_f(mode, int'(cand_dx), int'(cand_dy));
            pulses = pulses + 1;
            if (int'(cand_dx) != exp_dx || int'(cand_dy) != exp_dy)
                order_err = order_err + 1;
            if (exp_dx == 7) begin
                exp_dx = -8;
                exp_dy = exp_dy + 1;
            end else begin
                exp_dx = exp_dx + 1;
            end
        end
    end

    task automatic run_search(input int mode_i, input bit rnd, input bit inject,
                              output int cyc, output int dpulses, output logic mid_busy,
                              output logic signed [4:0] ldx, output logic signed [4:0] ldy,
                              output logic [11:0] lsad);
        int n;
        int post;
        cyc = 0; dpulses = 0; post = -1; mid_busy = 1'b0;
        mode = mode_i;
        @(posedge clk); #1;
        mon_clr = 1'b1; start = 1'b1; fetch_ready = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0; start = 1'b0; n = 1;
        ldx = cand_dx; ldy = cand_dy; lsad = best_sad;
        while (n < 3000 && post < 4) begin
            if (rnd) fetch_ready = 1'($urandom_range(0, 1));
            start = (inject && n == 50) || (inject && post == 0);
            @(posedge clk); #1;
            n++;
            if (n == 2) mid_busy = busy;
            if (post >= 0) post++;
            if (done) begin
                dpulses++;
                if (cyc == 0) begin
                    cyc = n;
                    post = 0;
                end
            end
        end
        start = 1'b0; fetch_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({pe_enable, busy, done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 000", {pe_enable, busy, done});
        end
        n_checks++;
        if (cand_dx !== 5'sd0 || cand_dy !== 5'sd0) begin
            n_fail++; $display("FAIL reset_cand: got %0d,%0d want 0,0", cand_dx, cand_dy);
        end
        n_checks++;
        if (best_sad !== 12'd0 || best_dx !== 5'sd0 || best_dy !== 5'sd0) begin
            n_fail++; $display("FAIL reset_best: got %0d (%0d,%0d) want 0 (0,0)", best_sad, best_dx, best_dy);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_main();
        int cyc, dp; logic mb; logic signed [4:0] ldx, ldy; logic [11:0] lsad;
        run_search(0, 1'b0, 1'b0, cyc, dp, mb, ldx, ldy, lsad);
        n_checks++;
        if (ldx !== -5'sd8 || ldy !== -5'sd8 || lsad !== 12'hFFF) begin
            n_fail++; $display("FAIL main_load: got %0d,%0d sad %0d want -8,-8 sad 4095", ldx, ldy, lsad);
        end
        n_checks++;
        if (mb !== 1'b1) begin
            n_fail++; $display("FAIL main_busy: got %b want 1", mb);
        end
        n_checks++;
        if (cyc != 258) begin
            n_fail++; $display("FAIL main_latency: got %0d want 258", cyc);
        end
        n_checks++;
        if (best_sad !== 12'd10 || best_dx !== 5'sd3 || best_dy !== -5'sd2) begin
            n_fail++; $display("FAIL main_best: got %0d (%0d,%0d) want 10 (3,-2)", best_sad, best_dx, best_dy);
        end
        n_checks++;
        if (pulses != 256 || order_err != 0 || dp != 1) begin
            n_fail++; $display("FAIL main_issue: pulses %0d order_err %0d done %0d want 256 0 1", pulses, order_err, dp);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL main_idle: busy %b done %b want 0 0", busy, done);
        end
        $display("test_main: cycles %0d best %0d (%0d,%0d)", cyc, best_sad, best_dx, best_dy);
    endtask

    task automatic test_tie();
        int cyc, dp; logic mb; logic signed [4:0] ldx, ldy; logic [11:0] lsad;
        run_search(1, 1'b0, 1'b0, cyc, dp, mb, ldx, ldy, lsad);
        n_checks++;
        if (best_sad !== 12'd50 || best_dx !== -5'sd8 || best_dy !== -5'sd8) begin
            n_fail++; $display("FAIL tie_best: got %0d (%0d,%0d) want 50 (-8,-8)", best_sad, best_dx, best_dy);
        end
        $display("test_tie: best %0d (%0d,%0d)", best_sad, best_dx, best_dy);
    endtask

    task automatic test_stall();
        int cyc, dp; logic mb; logic signed [4:0] ldx, ldy; logic [11:0] lsad;
        run_search(0, 1'b1, 1'b0, cyc, dp, mb, ldx, ldy, lsad);
        n_checks++;
        if (cyc < 258) begin
            n_fail++; $display("FAIL stall_latency: got %0d want >=258 (0 = timeout)", cyc);
        end
        n_checks++;
        if (pulses != 256 || order_err != 0) begin
            n_fail++; $display("FAIL stall_issue: pulses %0d order_err %0d want 256 0", pulses, order_err);
        end
        n_checks++;
        if (best_sad !== 12'd10 || best_dx !== 5'sd3 || best_dy !== -5'sd2 || dp != 1) begin
            n_fail++; $display("FAIL stall_best: got %0d (%0d,%0d) done %0d want 10 (3,-2) 1", best_sad, best_dx, best_dy, dp);
        end
        $display("test_stall: cycles %0d pulses %0d", cyc, pulses);
    endtask

    task automatic test_corner();
        int cyc, dp; logic mb; logic signed [4:0] ldx, ldy; logic [11:0] lsad;
        run_search(2, 1'b0, 1'b0, cyc, dp, mb, ldx, ldy, lsad);
        n_checks++;
        if (best_sad !== 12'd5 || best_dx !== 5'sd7 || best_dy !== 5'sd7) begin
            n_fail++; $display("FAIL corner_best: got %0d (%0d,%0d) want 5 (7,7)", best_sad, best_dx, best_dy);
        end
        $display("test_corner: best %0d (%0d,%0d)", best_sad, best_dx, best_dy);
    endtask

    task automatic test_start_ignored();
        int cyc, dp; logic mb; logic signed [4:0] ldx, ldy; logic [11:0] lsad;
        run_search(0, 1'b0, 1'b1, cyc, dp, mb, ldx, ldy, lsad);
        n_checks++;
        if (cyc != 258 || dp != 1) begin
            n_fail++; $display("FAIL ignore_start: cycles %0d done %0d want 258 1", cyc, dp);
        end
        n_checks++;
        if (busy !== 1'b0 || pulses != 256) begin
            n_fail++; $display("FAIL ignore_queue: busy %b pulses %0d want 0 256", busy, pulses);
        end
        n_checks++;
        if (best_sad !== 12'd10 || best_dx !== 5'sd3 || best_dy !== -5'sd2) begin
            n_fail++; $display("FAIL ignore_hold: got %0d (%0d,%0d) want 10 (3,-2)", best_sad, best_dx, best_dy);
        end
        $display("test_start_ignored: cycles %0d done pulses %0d", cyc, dp);
    endtask

    task automatic test_reset_mid();
        int cyc, dp, k, extra; logic mb; logic signed [4:0] ldx, ldy; logic [11:0] lsad;
        mode = 0;
        @(posedge clk); #1;
        mon_clr = 1'b1; start = 1'b1; fetch_ready = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0; start = 1'b0;
        k = 0;
        while (pulses < 100 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({pe_enable, busy, done} !== 3'b000 || cand_dx !== 5'sd0 || cand_dy !== 5'sd0 ||
            best_sad !== 12'd0 || best_dx !== 5'sd0 || best_dy !== 5'sd0) begin
            n_fail++;
            $display("FAIL midrst_clear: ctl %b cand %0d,%0d best %0d (%0d,%0d) want all 0",
                     {pe_enable, busy, done}, cand_dx, cand_dy, best_sad, best_dx, best_dy);
        end
        rst_n = 1'b1;
        extra = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++; $display("FAIL midrst_nodone: active cycles %0d want 0", extra);
        end
        run_search(0, 1'b0, 1'b0, cyc, dp, mb, ldx, ldy, lsad);
        n_checks++;
        if (cyc != 258 || best_sad !== 12'd10 || best_dx !== 5'sd3 || best_dy !== -5'sd2) begin
            n_fail++; $display("FAIL midrst_rerun: cycles %0d best %0d (%0d,%0d) want 258 10 (3,-2)",
                               cyc, best_sad, best_dx, best_dy);
        end
        $display("test_reset_mid: rerun cycles %0d", cyc);
    endtask

    initial begin
        test_reset();
        test_main();
        test_tie();
        test_stall();
        test_corner();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
